// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier-side producer, the accumulator and the result consumer.
// master drives jobs and products; slave is the accumulator.
interface product_accumulator_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      product;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             overflow;
  logic             busy;

  modport master (
    output start, len, in_valid, product, out_ready,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  start, len, in_valid, product, out_ready,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums a programmed number of 16-bit products into an ACC_W-bit total and emits one result beat.
// Optional macro PRODUCT_ACC_SAT_EN: clamp the accumulator on carry instead of wrapping.
module product_accumulator #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input logic                 clk,
  input logic                 rst,
  product_accumulator_if.slave bus
);

  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Returns {carry, new accumulator value}; the carry is kept even when clamping.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a, input logic [15:0] p);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + SUM_W'(p);
`ifdef PRODUCT_ACC_SAT_EN
    sum[ACC_W-1:0] = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`endif
    return sum;
  endfunction

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_next;
  logic             overflow;
  logic             overflow_next;
  logic [ACC_W:0]   sum;
  logic             in_ready;
  logic             out_valid;
  logic             busy;

  // State register and datapath registers; flags are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= {ACC_W{1'b0}};
      remaining <= {CNT_W{1'b0}};
      overflow  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      acc       <= acc_next;
      remaining <= remaining_next;
      overflow  <= overflow_next;
      in_ready  <= (state_next == ACCUM);
      out_valid <= (state_next == HOLD);
      busy      <= (state_next != IDLE);
    end
  end

  // Next-state and datapath update; in ACCUM in_ready is always high so in_valid alone transfers.
  always_comb begin
    state_next     = state;
    acc_next       = acc;
    remaining_next = remaining;
    overflow_next  = overflow;
    sum            = acc_add(acc, bus.product);
    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_next       = {ACC_W{1'b0}};
          overflow_next  = 1'b0;
          remaining_next = bus.len;
          if (bus.len == {CNT_W{1'b0}}) begin
            state_next = HOLD;
          end else begin
            state_next = ACCUM;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_next       = sum[ACC_W-1:0];
          overflow_next  = overflow | sum[ACC_W];
          remaining_next = remaining - CNT_ONE;
          if (remaining == CNT_ONE) begin
            state_next = HOLD;
          end else begin
            state_next = ACCUM;
          end
        end else begin
          state_next = ACCUM;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end else begin
          state_next = HOLD;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;
  assign bus.result    = acc;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized bench: two accumulators (ACC_W=24 and ACC_W=16) share one stimulus stream and are
// checked against a plain-arithmetic model of each job's total.
module tb_product_accumulator;

  typedef logic [15:0] prod_q_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] product;
  logic        out_ready;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(24), .CNT_W(8)) bus24();
  product_accumulator_if #(.ACC_W(16), .CNT_W(8)) bus16();

  assign bus24.start     = start;
  assign bus24.len       = len;
  assign bus24.in_valid  = in_valid;
  assign bus24.product   = product;
  assign bus24.out_ready = out_ready;
  assign bus16.start     = start;
  assign bus16.len       = len;
  assign bus16.in_valid  = in_valid;
  assign bus16.product   = product;
  assign bus16.out_ready = out_ready;

  product_accumulator #(.ACC_W(24), .CNT_W(8)) dut24 (.clk(clk), .rst(rst), .bus(bus24.slave));
  product_accumulator #(.ACC_W(16), .CNT_W(8)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected result of a job whose true (unbounded) sum is total, for a w-bit accumulator.
  function automatic logic [31:0] model_result(input longint total, input int w);
    longint maxv;
    maxv = (longint'(1) << w) - longint'(1);
`ifdef PRODUCT_ACC_SAT_EN
    return (total > maxv) ? 32'(maxv) : 32'(total);
`else
    return 32'(total & maxv);
`endif
  endfunction

  function automatic logic [31:0] model_ovf(input longint total, input int w);
    return (total > ((longint'(1) << w) - longint'(1))) ? 32'd1 : 32'd0;
  endfunction

  task automatic check_flags(input string tag, input logic ir, input logic ov, input logic bz);
    check_eq({tag, ".in_ready24"},  32'(bus24.in_ready),  32'(ir));
    check_eq({tag, ".out_valid24"}, 32'(bus24.out_valid), 32'(ov));
    check_eq({tag, ".busy24"},      32'(bus24.busy),      32'(bz));
    check_eq({tag, ".in_ready16"},  32'(bus16.in_ready),  32'(ir));
    check_eq({tag, ".out_valid16"}, 32'(bus16.out_valid), 32'(ov));
    check_eq({tag, ".busy16"},      32'(bus16.busy),      32'(bz));
  endtask

  task automatic check_zero(input string tag);
    check_flags(tag, 1'b0, 1'b0, 1'b0);
    check_eq({tag, ".result24"},   32'(bus24.result),   32'd0);
    check_eq({tag, ".overflow24"}, 32'(bus24.overflow), 32'd0);
    check_eq({tag, ".result16"},   32'(bus16.result),   32'd0);
    check_eq({tag, ".overflow16"}, 32'(bus16.overflow), 32'd0);
  endtask

  // One full job from IDLE; all driving and sampling happens on the falling edge.
  task automatic run_job(input string tag, input prod_q_t prods, input int stall_lo,
                         input int stall_hi, input int hold_cycles, input bit poke_start);
    longint total;
    int     L;
    total = 0;
    L     = prods.size();
    @(negedge clk);
    start = 1'b1;
    len   = 8'(L);
    @(negedge clk);
    start = 1'b0;
    check_flags({tag, ".accept"}, (L != 0), (L == 0), 1'b1);
    for (int i = 0; i < L; i++) begin
      repeat ($urandom_range(stall_hi, stall_lo)) begin
        in_valid = 1'b0;
        product  = 16'($urandom);
        start    = poke_start;
        len      = 8'd9;
        @(negedge clk);
        start = 1'b0;
        check_flags({tag, ".stall"}, 1'b1, 1'b0, 1'b1);
      end
      in_valid = 1'b1;
      product  = prods[i];
      total    = total + longint'(prods[i]);
      start    = poke_start;
      len      = 8'd9;
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
      if (i < L - 1) check_flags({tag, ".beat"}, 1'b1, 1'b0, 1'b1);
    end
    for (int h = 0; h <= hold_cycles; h++) begin
      check_flags({tag, ".hold"}, 1'b0, 1'b1, 1'b1);
      check_eq({tag, ".result24"},   32'(bus24.result),   model_result(total, 24));
      check_eq({tag, ".overflow24"}, 32'(bus24.overflow), model_ovf(total, 24));
      check_eq({tag, ".result16"},   32'(bus16.result),   model_result(total, 16));
      check_eq({tag, ".overflow16"}, 32'(bus16.overflow), model_ovf(total, 16));
      // Beats offered while holding must not be consumed.
      in_valid  = 1'b1;
      product   = 16'($urandom);
      start     = poke_start;
      len       = 8'd9;
      out_ready = (h == hold_cycles);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    start     = 1'b0;
    check_flags({tag, ".done"}, 1'b0, 1'b0, 1'b0);
    if (poke_start) begin
      repeat (3) @(negedge clk);
      check_flags({tag, ".no_restart"}, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    prod_q_t q;
    rst       = 1'b1;
    start     = 1'b0;
    len       = 8'd0;
    in_valid  = 1'b0;
    product   = 16'd0;
    out_ready = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    run_job("basic", q, 0, 0, 0, 1'b0);

    q = '{16'hFE01, 16'hFE01, 16'hFE01};
    run_job("stalls", q, 2, 2, 5, 1'b0);

    q = '{};
    run_job("zero_len", q, 0, 0, 3, 1'b0);

    q = '{16'hFFFF, 16'hFFFF};
    run_job("overflow", q, 0, 0, 1, 1'b0);
    q = '{16'h0001};
    run_job("after_ovf", q, 0, 0, 0, 1'b0);

    // Abandon a len=5 job after two beats with an asynchronous reset pulse.
    @(negedge clk);
    start = 1'b1;
    len   = 8'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      in_valid = 1'b1;
      product  = 16'h1234;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    q = '{16'h0007};
    run_job("post_reset", q, 0, 0, 0, 1'b0);

    q = '{16'($urandom), 16'($urandom)};
    run_job("start_ignored", q, 1, 2, 2, 1'b1);

    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(12, 0);
      q = '{};
      for (int k = 0; k < n; k++) begin
        q.push_back(($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom));
      end
      run_job($sformatf("rand%0d", j), q, 0, $urandom_range(2, 0), $urandom_range(3, 0),
              ($urandom_range(3, 0) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential accumulation stage directly downstream of the 8x8 unsigned multiplier. Consumes a stream of 16-bit products over a valid/ready handshake, sums a programmed number of them into a wide accumulator, and presents the total as a single result beat. Together the two blocks form a dot-product / MAC datapath. The multiplier stays combinational; all sequencing lives here.

## Interface
- ACC_W, default 24: accumulator and result width; legal range 16..32.
- CNT_W, default 8: width of the beat-count field; up to 2^CNT_W-1 products per job.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- len  input  CNT_W  number of products in the job; sampled with start.
- in_valid  input  1  product beat valid.
- in_ready  output  1  stage accepts a product this cycle.
- product  input  16  unsigned product from the multiplier.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  ACC_W  accumulated sum.
- overflow  output  1  sticky; the sum exceeded 2^ACC_W-1 during this job.
- busy  output  1  high in any state other than IDLE.

## Operation
- States: IDLE, ACCUM, HOLD.
- IDLE: in_ready=0, out_valid=0. On start=1: latch len into remaining, clear acc and overflow.
  - If len≠0, go to ACCUM.
  - If len=0, go directly to HOLD with result=0 and overflow=0.
- ACCUM: in_ready=1.
  - A beat transfers when in_valid&&in_ready.
  - On each transfer: acc ← acc + zero-extended product, then remaining ← remaining−1.
  - The transfer that takes remaining from 1 to 0 moves the FSM to HOLD.
  - A cycle with no in_valid leaves everything unchanged.
- HOLD: out_valid=1, in_ready=0. result and overflow are held stable until out_valid&&out_ready; that cycle returns the FSM to IDLE.
- start is ignored in ACCUM and HOLD. It is not queued.
- Arithmetic: an ACC_W+1-bit sum; bit ACC_W is the carry.
  - Carry=1 sets overflow, which stays set until the next accepted start or reset.
  - Without saturation, acc keeps the low ACC_W bits (wrap).
- rst asserted in any state:
  - FSM → IDLE.
  - acc, remaining, result, overflow → 0.
  - in_ready, out_valid, busy → 0.
  - A partially accumulated job is discarded without any result beat.

## Timing
- Reset values: in_ready=0, out_valid=0, result=0, overflow=0, busy=0.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid, out_ready or start to any output.
- start accepted at edge N: in_ready=1 from cycle N+1 (len≠0), or out_valid=1 from cycle N+1 (len=0).
- Throughput: one product per cycle while in_valid is held high.
- Latency: the last beat accepted at edge M gives out_valid=1 and the final result in cycle M+1.
- Result handshake accepted at edge K: busy=0 in cycle K+1; a start in cycle K+1 is accepted.
- Minimum job turnaround for len=L with no stalls: L+2 cycles from start to the next accepted start.

## Configuration
- PRODUCT_ACC_SAT_EN defined:
  - On carry, acc clamps to 2^ACC_W−1 and remains clamped for the rest of the job.
  - overflow is still set.
- PRODUCT_ACC_SAT_EN undefined: acc wraps modulo 2^ACC_W and overflow is set.
- Handshake, latency and state behaviour are identical in both builds.

## Test plan
- Basic job: len=4, products 0x0001, 0x0002, 0x0003, 0x0004 back-to-back.
  - out_valid one cycle after the 4th beat, result=10, overflow=0.
- Stalls: len=3, products 0xFE01 ×3, with in_valid low for 2 cycles between beats and out_ready held low 5 cycles.
  - result=0x2FA03 truncated to ACC_W=24 (0x02FA03), stable throughout HOLD.
- Zero length: start with len=0.
  - out_valid=1 the next cycle, result=0.
  - in_ready stays 0 throughout.
  - product beats offered are not consumed.
- Overflow (ACC_W=16, 2 beats of 0xFFFF):
  - Without PRODUCT_ACC_SAT_EN: result=0xFFFE, overflow=1.
  - With PRODUCT_ACC_SAT_EN: result=0xFFFF, overflow=1.
  - A following job with len=1, product=1: result=1, overflow=0.
- Reset mid-job: len=5, 2 beats accepted, then rst pulsed asynchronously between edges.
  - All outputs are 0 immediately.
  - A new job len=1, product=7 gives result=7.
- Start ignored: start pulsed with len=9 during ACCUM and during HOLD of a len=2 job.
  - The job completes after exactly 2 beats.
  - No second job begins without a fresh start in IDLE.
